mole_scheduler: RTL

Parametrised multi-mole scheduler for the mole game, the in-game timing core that sits between the stage manager and the LED/hole driver. Runs up to MAX_ACTIVE independent mole slots over NUM_HOLES holes. Each slot alternates random-length gaps with stage-dependent show windows. Accepts player hits, retiring a mole early, and reports hit, miss and wrong-hole events as single-cycle pulses.

---
 rtl/mole_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mole_scheduler.sv
// Multi-slot mole scheduler: each slot alternates random gaps with stage-timed
// show windows, retires on player hits and emits hit/miss/wrong event pulses.
module mole_scheduler #(
  parameter int unsigned NUM_HOLES  = 8,
  parameter int unsigned MAX_ACTIVE = 3,
  parameter int unsigned CLK_PER_MS = 1000,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned SHOW_MS_S1 = 1000,
  parameter int unsigned SHOW_MS_S2 = 750,
  parameter int unsigned SHOW_MS_S3 = 500,
  parameter int unsigned GAP_MS_S1  = 500,
  parameter int unsigned GAP_MS_S2  = 250,
  parameter int unsigned GAP_MS_S3  = 200
) (
  input  logic                         clk_1mhz,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [1:0]                   gsm_stage,
  input  logic                         hit_valid,
  input  logic [$clog2(NUM_HOLES)-1:0] hit_pos,
  output logic [NUM_HOLES-1:0]         mole_mask,
  output logic                         hit_pulse,
  output logic                         miss_pulse,
  output logic                         wrong_pulse
);

  localparam int unsigned HW   = $clog2(NUM_HOLES);
  localparam int unsigned PW   = $clog2(CLK_PER_MS);
  localparam int unsigned CW   = 11;
  localparam int unsigned LIM2 = (MAX_ACTIVE < 2) ? MAX_ACTIVE : 2;

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_GAP, SLOT_SHOW} slot_state_t;

  logic [15:0]   lfsr;
  logic [PW-1:0] pre_cnt;
  logic          ms_tick_c;

  slot_state_t   slot_st   [MAX_ACTIVE];
  logic [HW-1:0] slot_hole [MAX_ACTIVE];
  logic [CW-1:0] slot_cnt  [MAX_ACTIVE];

  logic [2:0]            lim_c;
  logic [CW-1:0]         show_ld_c;
  logic [CW-1:0]         gap_ld_c;
  logic [15:0]           gap_mod1_c, gap_mod2_c, gap_mod3_c;
  logic [MAX_ACTIVE-1:0] in_lim_c, hit_c, expire_c, spawn_c;
  logic [HW-1:0]         cand_c [MAX_ACTIVE];
  logic [NUM_HOLES-1:0]  mask_nxt_c;

  // Free-running random source, independent of enable
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Millisecond prescaler
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n)                     pre_cnt <= '0;
    else if (!enable || ms_tick_c)  pre_cnt <= '0;
    else                            pre_cnt <= pre_cnt + PW'(1);
  end

  assign ms_tick_c = enable && (pre_cnt == PW'(CLK_PER_MS - 1));

  // Per-stage random gap reductions use constant divisors only
  assign gap_mod1_c = lfsr % 16'(GAP_MS_S1);
  assign gap_mod2_c = lfsr % 16'(GAP_MS_S2);
  assign gap_mod3_c = lfsr % 16'(GAP_MS_S3);

  always_comb begin
    lim_c     = 3'(1);
    show_ld_c = CW'(SHOW_MS_S1);
    gap_ld_c  = CW'(gap_mod1_c) + CW'(1);
    case (gsm_stage)
      2'b10: begin
        lim_c     = 3'(LIM2);
        show_ld_c = CW'(SHOW_MS_S2);
        gap_ld_c  = CW'(gap_mod2_c) + CW'(1);
      end
      2'b11: begin
        lim_c     = 3'(MAX_ACTIVE);
        show_ld_c = CW'(SHOW_MS_S3);
        gap_ld_c  = CW'(gap_mod3_c) + CW'(1);
      end
      default: ;
    endcase
  end

  // Hit/expiry detection, collision-free spawn arbitration (lower slot wins)
  always_comb begin
    logic [MAX_ACTIVE-1:0] spawn_v;
    logic                  blocked;
    logic                  show_nxt;
    logic [HW-1:0]         hole_nxt;
    spawn_v    = '0;
    mask_nxt_c = '0;
    in_lim_c   = '0;
    hit_c      = '0;
    expire_c   = '0;
    for (int k = 0; k < MAX_ACTIVE; k++) begin
      in_lim_c[k] = 3'(k) < lim_c;
      cand_c[k]   = HW'(({1'b0, lfsr[7:0]} + 9'(5 * k)) % 9'(NUM_HOLES));
      hit_c[k]    = hit_valid && (slot_st[k] == SLOT_SHOW) && (slot_hole[k] == hit_pos);
      expire_c[k] = ms_tick_c && (slot_st[k] == SLOT_SHOW) && (slot_cnt[k] == CW'(1)) && !hit_c[k];
    end
    for (int k = 0; k < MAX_ACTIVE; k++) begin
      blocked = 1'b0;
      for (int j = 0; j < MAX_ACTIVE; j++) begin
        if ((slot_st[j] == SLOT_SHOW) && (slot_hole[j] == cand_c[k])) blocked = 1'b1;
        if ((j < k) && spawn_v[j] && (cand_c[j] == cand_c[k]))         blocked = 1'b1;
      end
      spawn_v[k] = ms_tick_c && (slot_st[k] == SLOT_GAP) && (slot_cnt[k] == CW'(1)) &&
                   in_lim_c[k] && !blocked;
    end
    for (int k = 0; k < MAX_ACTIVE; k++) begin
      show_nxt = spawn_v[k] || ((slot_st[k] == SLOT_SHOW) && !hit_c[k] && !expire_c[k]);
      hole_nxt = spawn_v[k] ? cand_c[k] : slot_hole[k];
      for (int h = 0; h < NUM_HOLES; h++) begin
        if (show_nxt && (hole_nxt == HW'(h))) mask_nxt_c[h] = 1'b1;
      end
    end
    spawn_c = spawn_v;
  end

  // Slot state machines and registered outputs
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_ACTIVE; k++) begin
        slot_st[k]   <= SLOT_IDLE;
        slot_hole[k] <= '0;
        slot_cnt[k]  <= '0;
      end
      mole_mask   <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      wrong_pulse <= 1'b0;
    end else if (!enable) begin
      for (int k = 0; k < MAX_ACTIVE; k++) begin
        slot_st[k]   <= SLOT_IDLE;
        slot_hole[k] <= '0;
        slot_cnt[k]  <= '0;
      end
      mole_mask   <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      wrong_pulse <= 1'b0;
    end else begin
      for (int k = 0; k < MAX_ACTIVE; k++) begin
        case (slot_st[k])
          SLOT_IDLE: begin
            if (in_lim_c[k]) begin
              slot_st[k]  <= SLOT_GAP;
              slot_cnt[k] <= gap_ld_c;
            end
          end
          SLOT_GAP: begin
            if (ms_tick_c) begin
              if (slot_cnt[k] != CW'(1)) begin
                slot_cnt[k] <= slot_cnt[k] - CW'(1);
              end else if (!in_lim_c[k]) begin
                slot_st[k] <= SLOT_IDLE;
              end else if (spawn_c[k]) begin
                slot_st[k]   <= SLOT_SHOW;
                slot_hole[k] <= cand_c[k];
                slot_cnt[k]  <= show_ld_c;
              end
            end
          end
          SLOT_SHOW: begin
            if (hit_c[k] || expire_c[k]) begin
              slot_st[k]  <= SLOT_GAP;
              slot_cnt[k] <= gap_ld_c;
            end else if (ms_tick_c) begin
              slot_cnt[k] <= slot_cnt[k] - CW'(1);
            end
          end
          default: slot_st[k] <= SLOT_IDLE;
        endcase
      end
      mole_mask   <= mask_nxt_c;
      hit_pulse   <= |hit_c;
      miss_pulse  <= |expire_c;
      wrong_pulse <= hit_valid && !(|hit_c);
    end
  end

endmodule
